// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: boot FSM state codes, NOP word and byte-to-word index helper
package imem_boot_loader_pkg;

   typedef logic [1:0] boot_state_t;

   localparam boot_state_t S_CLEAR = 2'd0;
   localparam boot_state_t S_LOAD  = 2'd1;
   localparam boot_state_t S_HOLD  = 2'd2;
   localparam boot_state_t S_RUN   = 2'd3;

   // sll r0,r0,0: what every unwritten or out-of-range word reads as
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   function automatic logic [63:0] word_idx(input logic [63:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/imem_boot_loader_ram.sv
// imem_boot_loader_ram: DEPTH x DATA_W instruction store, one sync write port, one async read port
module imem_boot_loader_ram #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: clears IMEM, streams a program into it, then holds the cpu in reset
// for HOLD_CYC cycles before releasing it; supports in-place reload from RUN.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int DATA_W          = 32,
   parameter int ADDR_W          = 32,
   parameter int DEPTH           = 64,
   parameter int HOLD_CYC        = 4,
   parameter int CLEAR_ON_RELOAD = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [ADDR_W-1:0]          s_addr,
   input  logic [DATA_W-1:0]          s_data,
   input  logic                       s_last,
   input  logic                       reload,
   input  logic [ADDR_W-1:0]          fetch_addr,
   output logic [DATA_W-1:0]          fetch_data,
   output logic                       cpu_rst,
   output logic                       initialize,
   output logic [$clog2(DEPTH+1)-1:0] load_count,
   output logic                       err_misalign,
   output logic                       err_range
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LCW = $clog2(DEPTH+1);
   localparam int HW  = $clog2(HOLD_CYC+1);

   boot_state_t       state;
   logic [AW-1:0]     clr_idx;
   logic [HW-1:0]     hold_cnt;
   logic [63:0]       s_widx, f_widx;
   logic              accept, bad_align, bad_range, s_wr, we;
   logic [AW-1:0]     waddr, raddr;
   logic [DATA_W-1:0] wdata, rdata;

   assign s_ready    = state == S_LOAD;
   assign cpu_rst    = state != S_RUN;
   assign initialize = state != S_RUN;

   assign s_widx    = word_idx(64'(s_addr));
   assign accept    = s_valid && s_ready;
   assign bad_align = s_addr[1:0] != 2'b00;
   assign bad_range = s_widx >= 64'(DEPTH);
   assign s_wr      = accept && !bad_align && !bad_range;

   // CLEAR owns the write port; in LOAD only clean beats reach it
   assign we    = (state == S_CLEAR) || s_wr;
   assign waddr = (state == S_CLEAR) ? clr_idx : s_widx[AW-1:0];
   assign wdata = (state == S_CLEAR) ? DATA_W'(NOP_WORD) : s_data;

   assign f_widx     = word_idx(64'(fetch_addr));
   assign raddr      = f_widx[AW-1:0];
   assign fetch_data = (f_widx < 64'(DEPTH)) ? rdata : DATA_W'(NOP_WORD);

   imem_boot_loader_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_CLEAR;
         clr_idx      <= '0;
         hold_cnt     <= '0;
         load_count   <= '0;
         err_misalign <= 1'b0;
         err_range    <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_idx <= (clr_idx == AW'(DEPTH-1)) ? '0 : clr_idx + 1'b1;
               if (clr_idx == AW'(DEPTH-1)) state <= S_LOAD;
            end
            S_LOAD: begin
               if (s_wr && load_count != LCW'(DEPTH)) load_count <= load_count + 1'b1;
               if (accept && bad_align) err_misalign <= 1'b1;
               if (accept && bad_range) err_range <= 1'b1;
               if (accept && s_last) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
               end
            end
            S_HOLD: begin
               if (hold_cnt == HW'(HOLD_CYC-1)) state <= S_RUN;
               else hold_cnt <= hold_cnt + 1'b1;
            end
            default: begin
               if (reload) begin
                  state        <= (CLEAR_ON_RELOAD != 0) ? S_CLEAR : S_LOAD;
                  clr_idx      <= '0;
                  load_count   <= '0;
                  err_misalign <= 1'b0;
                  err_range    <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed boot/load/hold/reload/reset sequence with hand-computed expectations
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready, s_last, reload;
   logic [31:0] s_addr, s_data, fetch_addr, fetch_data;
   logic        cpu_rst, initialize, err_misalign, err_range;
   logic [6:0]  load_count;

   int checks   = 0;
   int failures = 0;
   int n;

   imem_boot_loader #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(64), .HOLD_CYC(4), .CLEAR_ON_RELOAD(1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_addr       (s_addr),
      .s_data       (s_data),
      .s_last       (s_last),
      .reload       (reload),
      .fetch_addr   (fetch_addr),
      .fetch_data   (fetch_data),
      .cpu_rst      (cpu_rst),
      .initialize   (initialize),
      .load_count   (load_count),
      .err_misalign (err_misalign),
      .err_range    (err_range)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      fetch_addr = addr;
      #1;
      chk(tag, fetch_data, exp);
   endtask

   task automatic beat(input logic [31:0] addr, input logic [31:0] data, input logic last);
      s_valid = 1'b1;
      s_addr  = addr;
      s_data  = data;
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!s_ready && cnt < 200) begin
         tick();
         cnt++;
      end
   endtask

   task automatic wait_run(output int cnt);
      cnt = 0;
      while (cpu_rst && cnt < 50) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; reload = 1'b0;
      s_addr = '0; s_data = '0; fetch_addr = '0;
      // 1: reset then clear sweep
      repeat (3) tick();
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_cpu_rst", 32'(cpu_rst), 1);
      chk("rst_initialize", 32'(initialize), 1);
      chk("rst_load_count", 32'(load_count), 0);
      chk("rst_errs", {30'd0, err_misalign, err_range}, 0);
      rst = 1'b1;
      wait_ready(n);
      chk("clear_cycles", n, 64);
      fetch("clr_fetch0", 0, 0);
      fetch("clr_fetch4", 4, 0);
      fetch("clr_fetch252", 252, 0);
      chk("load_cpu_rst", 32'(cpu_rst), 1);
      // 2/3: program beats with a misaligned and an out-of-range beat in between
      beat(0, 32'h00020820, 1'b0);
      beat(4, 32'h00844022, 1'b0);
      chk("count_2", 32'(load_count), 2);
      beat(6, 32'hDEADBEEF, 1'b0);
      chk("misalign_flag", 32'(err_misalign), 1);
      chk("misalign_range_clr", 32'(err_range), 0);
      chk("misalign_count", 32'(load_count), 2);
      beat(256, 32'hCAFEF00D, 1'b0);
      chk("range_flag", 32'(err_range), 1);
      chk("range_count", 32'(load_count), 2);
      // 4: keep s_valid high with junk through HOLD/RUN; reload during HOLD is ignored
      s_valid = 1'b1; s_addr = 8; s_data = 32'h00A63825; s_last = 1'b1;
      tick();
      s_addr = 0; s_data = 32'h11111111; s_last = 1'b0;
      chk("count_3", 32'(load_count), 3);
      chk("hold_s_ready", 32'(s_ready), 0);
      chk("hold_cpu_rst", 32'(cpu_rst), 1);
      reload = 1'b1;
      tick();
      reload = 1'b0;
      wait_run(n);
      chk("hold_cycles", n + 1, 4);
      chk("run_initialize", 32'(initialize), 0);
      chk("run_s_ready", 32'(s_ready), 0);
      repeat (3) tick();
      s_valid = 1'b0;
      chk("run_count", 32'(load_count), 3);
      fetch("fetch0", 0, 32'h00020820);
      fetch("fetch4", 4, 32'h00844022);
      fetch("fetch6", 6, 32'h00844022);
      fetch("fetch8", 8, 32'h00A63825);
      fetch("fetch12_unwritten", 12, 0);
      fetch("fetch256_range", 256, 0);
      chk("run_errs", {30'd0, err_misalign, err_range}, 32'd3);
      // 5: reload from RUN
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("reload_cpu_rst", 32'(cpu_rst), 1);
      chk("reload_initialize", 32'(initialize), 1);
      chk("reload_count", 32'(load_count), 0);
      chk("reload_errs", {30'd0, err_misalign, err_range}, 0);
      wait_ready(n);
      chk("reload_clear_cycles", n, 64);
      fetch("reload_fetch4", 4, 0);
      beat(0, 32'h8C0C000C, 1'b1);
      chk("reload_count1", 32'(load_count), 1);
      wait_run(n);
      chk("reload_hold_cycles", n, 4);
      fetch("reload_fetch0", 0, 32'h8C0C000C);
      fetch("reload_fetch8", 8, 0);
      // 6: reset in the middle of LOAD
      reload = 1'b1;
      tick();
      reload = 1'b0;
      wait_ready(n);
      beat(0, 32'h12345678, 1'b0);
      beat(4, 32'h9ABCDEF0, 1'b0);
      chk("mid_count2", 32'(load_count), 2);
      fetch("mid_fetch4", 4, 32'h9ABCDEF0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_cpu_rst", 32'(cpu_rst), 1);
      chk("mid_rst_count", 32'(load_count), 0);
      chk("mid_rst_s_ready", 32'(s_ready), 0);
      wait_ready(n);
      chk("mid_rst_clear_cycles", n, 64);
      for (int i = 0; i < 64; i++) fetch($sformatf("mid_word%0d", i), 32'(i * 4), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
